serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/adder.sv | 22 ++
 rtl/serial_adder.sv | 183 ++++++++++++++++++
 tb/tb_serial_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder.
//   - ST_IDLE / ST_RUN / ST_DONE : state encodings
//   - state_t                    : FSM state type built on those encodings
//   - DEFAULT_WIDTH              : default operand/sum width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// 1-bit full-adder cell used as the per-bit arithmetic element.
// Ports (in cell order):
//   a    : input  operand bit A
//   b    : input  operand bit B
//   cin  : input  carry in
//   cout : output carry out
//   s    : output sum bit
// -----------------------------------------------------------------------------
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic s
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder. Operands are latched on an accepted start and
// fed LSB first, one bit pair per clock, through a single full-adder cell.
// The cell carry is registered and fed back. After WIDTH bit cycles the sum
// and final carry are published on s/cout with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a `sub` input exists; sub = 1 on accept loads ~b and a
//   carry-in of 1 so the block computes a - b (cout = 1 means no borrow).
//   When undefined the block is add-only with no inverter on the b path.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request, accepted in IDLE or DONE (i.e. whenever busy = 0)
//   a, b  : WIDTH-bit operands, sampled on the accepting edge
//   cin   : initial carry-in, sampled on the accepting edge
//   sub   : subtract select (SERIAL_ADDER_SUB_EN only)
//   busy  : high while bits are being processed (state RUN)
//   done  : one-cycle pulse, s/cout just updated (state DONE)
//   s     : sum result register, holds until the next completion
//   cout  : final carry-out register, holds until the next completion
//
// Handshake: start is a level request sampled on each rising edge; it is
// taken only when busy = 0, and ignored (not queued) while busy = 1.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // FSM state; kept as a named register so checkers can bind to it.
    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic             w_accept;
    logic             w_step;
    logic             w_finish;
    logic             w_bit_s;
    logic             w_bit_cout;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_load_b;
    logic             w_load_c;

    // Values captured on an accepting edge.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_load_b = sub ? ~b : b;
    assign w_load_c = sub ? 1'b1 : cin;
`else
    assign w_load_b = b;
    assign w_load_c = cin;
`endif

    // Single full-adder cell working on the current LSB pair.
    adder u_adder (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .cout (w_bit_cout),
        .s    (w_bit_s)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result
    // sits at bit 0. The cast drops the shifted-out LSB and also covers
    // WIDTH = 1 without a special case.
    assign w_sum_next = WIDTH'({w_bit_s, r_sum_sh} >> 1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // DONE is a busy = 0 cycle, so a new request is taken here.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum_sh <= '0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= w_load_b;
            r_carry <= w_load_c;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_carry  <= w_bit_cout;
            r_cnt    <= r_cnt + CNT_W'(1);
            r_sum_sh <= w_sum_next;
        end
    end

    // Result registers only change on completion (or reset).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else if (w_finish) begin
            r_s    <= w_sum_next;
            r_cout <= w_bit_cout;
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign s    = r_s;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operation, wait for done (bounded), check timing and result.
  task automatic run_op(input vec_t v);
    int lat;
    int busy_cyc;
    @(negedge clk);
    a = v.a;
    b = v.b;
    cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = v.sub;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_cyc), 32'(W));
    check("done_high", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("sum", 32'(s), 32'(v.exp_s));
    check("cout", 32'(cout), 32'(v.exp_cout));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int pulses;
    int gap;
    logic [W-1:0] cap_s;

    // expected results, hand-computed
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
    vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h37, 8'h37, 1'b0, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h21, 8'h10, 1'b1, 1'b0, 8'h32, 1'b0});
`endif

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    // table-driven vectors
    foreach (vecs[i]) run_op(vecs[i]);

    // results hold through idle cycles
    run_op('{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0});
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      @(negedge clk);
      check("hold_s", 32'(s), 32'h97);
      check("hold_cout", 32'(cout), 32'd0);
      check("hold_done", 32'(done), 32'd0);
    end

    // start while busy is ignored
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00;
    check("ignored_start_busy", 32'(busy), 32'd1);
    pulses = 0;
    cap_s = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        cap_s = s;
      end
      @(negedge clk);
    end
    check("ignored_start_pulses", 32'(pulses), 32'd1);
    check("ignored_start_sum", 32'(cap_s), 32'h02);

    // reset in the middle of a run
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(pulses), 32'd0);

    // back-to-back with start held high; second accept happens in DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    gap = 0;
    while (!done && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_sum", 32'(s), 32'h30);
    gap = 0;
    do begin
      gap++;
      @(negedge clk);
    end while (!done && gap < 40);
    start = 1'b0;
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_sum", 32'(s), 32'h07);
    // 8 non-done cycles between the two pulses
    check("b2b_spacing", 32'(gap), 32'(W + 1));
    @(negedge clk);
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; a = 8'h44; b = 8'h11;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_s", 32'(s), 32'd0);
    @(negedge clk);
    check("rst_start_no_accept", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
